// File: rtl/mic_array_pkg.sv
// Shared definitions for the microphone array capture front end.
//   DATA_W / CHAN_W / ERR_W : widths of the 32-bit mic input stream fields
//   ERR_OVERRUN             : error bit set on the first beat of a restarted burst
//   emit_state_e            : beat emitter states
package mic_array_pkg;

  localparam int DATA_W      = 32;
  localparam int CHAN_W      = 5;
  localparam int ERR_W       = 2;
  localparam int ERR_OVERRUN = 0;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } emit_state_e;

endpackage

// File: rtl/mic_i2s_clkgen.sv
// I2S bit clock / word select generator shared by every microphone line.
//   clk, reset, enable : system clock, sync active-high reset, capture enable
//   mic_sck            : bit clock, toggles every CLK_DIV clk cycles
//   mic_ws             : word select (0 = left slot), changes with sck falling
//   frame_start        : one-cycle pulse after bit_cnt wraps 63 -> 0
//   bit_cnt            : bit position within the 64-bit frame
//   rise_tick          : high in the cycle whose clk edge raises mic_sck
//   fall_tick          : high in the cycle whose clk edge lowers mic_sck
module mic_i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       mic_sck,
  output logic       mic_ws,
  output logic       frame_start,
  output logic [5:0] bit_cnt,
  output logic       rise_tick,
  output logic       fall_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick      = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = tick && !mic_sck;
  assign fall_tick = tick && mic_sck;

  // bit_cnt is a flop, so word select is registered and moves only on sck fall.
  assign mic_ws = bit_cnt[5];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt     <= '0;
      mic_sck     <= 1'b0;
      bit_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      frame_start <= fall_tick && (bit_cnt == 6'd63);
      if (tick) begin
        mic_sck <= ~mic_sck;
      end
      if (fall_tick) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/mic_i2s_array_rx.sv
// Microphone array I2S receiver: drives sck/ws to all mics, deserialises
// NUM_LINES data lines (left/right pair each) and emits one stream beat per
// microphone after each slot's last significant bit.
//   clk, reset, enable  : system clock, sync active-high reset, capture enable
//   mic_sd              : serial data, line i carries channels 2i and 2i+1
//   mic_sck, mic_ws     : shared bit clock and word select
//   mic_output_*        : 32-bit mic stream (data, channel, error, valid)
//   frame_start         : pulse at the start of every 64-bit frame
module mic_i2s_array_rx
  import mic_array_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int CLK_DIV        = 4,
  parameter int SAMPLE_BITS    = 24,
  parameter int STARTUP_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LINES-1:0] mic_sd,
  output logic                 mic_sck,
  output logic                 mic_ws,
  output logic [DATA_W-1:0]    mic_output_data,
  output logic [CHAN_W-1:0]    mic_output_channel,
  output logic [ERR_W-1:0]     mic_output_error,
  output logic                 mic_output_valid,
  output logic                 frame_start
);

  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int SU_W   = $clog2(STARTUP_FRAMES + 1);

  logic [5:0] bit_cnt;
  logic       rise_tick;
  logic       fall_tick;

  mic_i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mic_sck    (mic_sck),
    .mic_ws     (mic_ws),
    .frame_start(frame_start),
    .bit_cnt    (bit_cnt),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick)
  );

  // Slot bit 0 is the I2S one-bit delay after the ws edge; bits 1..SAMPLE_BITS
  // carry the sample MSB first, anything after is padding.
  logic [4:0] slot_bit;
  logic       capture;
  logic       latch;

  assign slot_bit = bit_cnt[4:0];
  assign capture  = rise_tick && (slot_bit >= 5'd1) && (slot_bit <= 5'(SAMPLE_BITS));
  assign latch    = rise_tick && (slot_bit == 5'(SAMPLE_BITS));

  logic [SAMPLE_BITS-1:0] shift_q    [NUM_LINES];
  logic [SAMPLE_BITS-1:0] shift_next [NUM_LINES];
  logic [SAMPLE_BITS-1:0] hold_q     [NUM_LINES];

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      shift_next[i] = {shift_q[i][SAMPLE_BITS-2:0], mic_sd[i]};
    end
  end

  // NOTE: the shift and holding registers are pure datapath and carry no
  // reset; nothing reads them until a full slot has been shifted in and the
  // emitter (which is reset) gates every output with valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LINES; i++) begin
      if (capture) begin
        shift_q[i] <= shift_next[i];
      end
      // The latch edge also shifts in the last bit, so take the post-shift value.
      if (latch) begin
        hold_q[i] <= shift_next[i];
      end
    end
  end

  emit_state_e       state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              slot_q, slot_d;
  logic              ovr_q, ovr_d;
  logic [SU_W-1:0]   startup_q;
  logic              emit_ok;

  assign emit_ok = (startup_q == SU_W'(STARTUP_FRAMES));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q   <= IDLE;
      line_q    <= '0;
      slot_q    <= 1'b0;
      ovr_q     <= 1'b0;
      startup_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      slot_q  <= slot_d;
      ovr_q   <= ovr_d;
      if (frame_start && !emit_ok) begin
        startup_q <= startup_q + SU_W'(1);
      end
    end
  end

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    slot_d  = slot_q;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (latch) begin
          state_d = EMIT;
          line_d  = '0;
          slot_d  = bit_cnt[5];
        end
      end
      EMIT: begin
        if (latch) begin
          // New samples arrived before the burst finished: restart and flag it.
          line_d = '0;
          slot_d = bit_cnt[5];
          ovr_d  = 1'b1;
        end else if (line_q == LINE_W'(NUM_LINES - 1)) begin
          state_d = IDLE;
          line_d  = '0;
        end else begin
          line_d = line_q + LINE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beats are decoded straight from the emitter flops; startup frames run the
  // emitter but keep valid low.
  logic [SAMPLE_BITS-1:0] cur_sample;

  assign cur_sample = hold_q[line_q];

  always_comb begin
    mic_output_valid   = (state_q == EMIT) && emit_ok;
    mic_output_data    = '0;
    mic_output_channel = '0;
    mic_output_error   = '0;
    if (mic_output_valid) begin
      mic_output_data    = {{(DATA_W - SAMPLE_BITS){cur_sample[SAMPLE_BITS-1]}}, cur_sample};
      mic_output_channel = CHAN_W'({line_q, slot_q});
      mic_output_error[ERR_OVERRUN] = ovr_q;
    end
  end

endmodule

// File: doc/mic_i2s_array_rx.md
Name: mic_i2s_array_rx

Overview:
Front-end capture stage for the microphone array. Generates the shared I2S bit clock and word select for all microphones. Deserialises NUM_LINES serial data lines, each carrying a left/right microphone pair. Emits one Avalon-ST beat per microphone per frame on the system's 32-bit mic input stream (data, channel, error, valid; no backpressure).

Parameters:
NUM_LINES, 8, number of mic_sd lines (2 mics per line; 2*NUM_LINES <= 32)
CLK_DIV, 4, clk cycles per mic_sck half-period (>= 2)
SAMPLE_BITS, 24, significant bits per slot, MSB-first (<= 31)
STARTUP_FRAMES, 2, frames discarded after reset or enable rise (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  capture enable; low stops clocks and clears counters
mic_sd  in  NUM_LINES  serial data, line i carries channels 2i (left) and 2i+1 (right)
mic_sck  out  1  I2S bit clock, registered
mic_ws  out  1  word select, 0 = left slot, registered
mic_output_data  out  32  sign-extended sample
mic_output_channel  out  5  2*line + slot
mic_output_error  out  2  [0] overrun, [1] reserved 0
mic_output_valid  out  1  beat strobe, single-cycle per beat
frame_start  out  1  one-cycle pulse when bit_cnt wraps 63->0

Behaviour:
- Reset or enable=0: all outputs 0; div_cnt, bit_cnt, startup counter and emit state cleared. Takes effect on the next clk edge, including mid-frame or mid-burst; any burst in progress is dropped.
- Divider: div_cnt counts 0..CLK_DIV-1. A tick occurs at CLK_DIV-1, and mic_sck toggles on each tick. The first rising tick occurs CLK_DIV cycles after enable is high and reset is low.
- bit_cnt (6 bits) increments on each falling tick and wraps 63->0. mic_ws = bit_cnt[5], so ws changes only with sck falling. frame_start pulses on the wrap.
- Capture: on each rising tick, every mic_sd bit is sampled. Slot bit b = bit_cnt[4:0]. Bits with b = 1..SAMPLE_BITS shift MSB-first into a per-line shift register (one-bit I2S delay after ws edge). Other bits are ignored.
- Latch: on the rising tick with b == SAMPLE_BITS, all shift registers copy into holding registers, together with slot s = bit_cnt[5].
- Emit state machine: IDLE -> EMIT on latch. In EMIT, emit line k = 0..NUM_LINES-1 in consecutive clk cycles, then return to IDLE.
  - First beat is valid 1 clk after the latch cycle.
  - Each beat: channel = 2k + s; data = SAMPLE_BITS sample sign-extended to 32.
- Startup: frames are counted by frame_start. While fewer than STARTUP_FRAMES full frames have completed, latches occur but valid stays 0. The first emitted burst is slot 0 of frame index STARTUP_FRAMES.
- Overrun: a latch while in EMIT aborts the old burst and restarts at line 0 with the new data. error[0] = 1 on that first new beat only. This cannot occur when NUM_LINES < 64*CLK_DIV; the condition is reachable only by forcing the state in verification.
- Simultaneous reset and latch: reset wins.
- Simultaneous enable fall and beat: no beat is emitted.

Decomposition:
- Shared package mic_array_pkg:
  - DATA_W = 32, CHAN_W = 5, ERR_W = 2
  - error bit index constants ERR_OVERRUN = 0
  - emit state enum {IDLE, EMIT}
- One natural sub-module: mic_i2s_clkgen, which owns div_cnt, bit_cnt, mic_sck, mic_ws, frame_start and the rise/fall tick strobes.
- Per-line shift registers and the emit FSM stay in the top level.

Test Plan:
- Reset released, enable=1, CLK_DIV=4 -> mic_sck first rises at cycle 4, period 8 clk; mic_ws toggles every 256 clk; frame_start every 512 clk.
- Line 0 left drives 0x800001, line 3 right drives 0x123456 (defaults, after 2 discarded frames) -> beats channel 0 data 0xFF800001 and channel 7 data 0x00123456. Eight consecutive valid beats per slot; channels 0,2,...,14 for the left slot, then 1,3,...,15 for the right slot.
- Startup count -> no valid in frames 0 and 1; first valid beat 1 clk after the latch tick (b=24) of frame 2, slot 0.
- enable dropped mid-burst at beat 3 -> valid low next cycle; mic_sck and mic_ws return to 0. On re-enable, 2 frames are discarded again.
- reset asserted mid-frame with enable=1 -> all outputs 0 next cycle; timing restarts identically to the first scenario.
- Forced latch during EMIT (force emit state) -> burst restarts at channel s, error[0]=1 on that beat only, 0 on all following beats.
